// File: rtl/fill_partition_stage.sv
// Pivot-partition fill stage: counts pixels below/equal/above a pivot over one window,
// tracks min/max of the outer partitions and reports which partition holds rank k.
module fill_partition_stage #(
  parameter  int DATA_WIDTH = 8,
  parameter  int BUFF_SIZE  = 32,
  localparam int SIZE_BIT   = $clog2(BUFF_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] cfg_pivot,
  input  logic [SIZE_BIT-1:0]   cfg_size,
  input  logic [SIZE_BIT-1:0]   cfg_rank,
  input  logic [DATA_WIDTH-1:0] in_px,
  input  logic                  in_px_valid,
  output logic                  in_px_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [SIZE_BIT-1:0]   res_lower_cnt,
  output logic [SIZE_BIT-1:0]   res_equal_cnt,
  output logic [SIZE_BIT-1:0]   res_larger_cnt,
  output logic [DATA_WIDTH-1:0] res_min_lower,
  output logic [DATA_WIDTH-1:0] res_max_lower,
  output logic [DATA_WIDTH-1:0] res_min_larger,
  output logic [DATA_WIDTH-1:0] res_max_larger,
  output logic [1:0]            res_sel,
  output logic [SIZE_BIT-1:0]   res_rank,
  output logic                  res_err,
  output logic                  filling
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_e;

  state_e state_q, state_d;
  logic   alive_q;

  logic [DATA_WIDTH-1:0] pivot_q;
  logic [SIZE_BIT-1:0]   size_q, rank_q, cnt_q;
  logic [SIZE_BIT-1:0]   lower_q, equal_q, larger_q;
  logic [DATA_WIDTH-1:0] min_lower_q, max_lower_q, min_larger_q, max_larger_q;

  logic [SIZE_BIT-1:0]   lower_d, equal_d, larger_d, cnt_d;
  logic [DATA_WIDTH-1:0] min_lower_d, max_lower_d, min_larger_d, max_larger_d;
  logic [1:0]            sel_d;
  logic [SIZE_BIT-1:0]   rank_d;

  logic [SIZE_BIT-1:0]   res_lower_q, res_equal_q, res_larger_q, res_rank_q;
  logic [DATA_WIDTH-1:0] res_min_lower_q, res_max_lower_q, res_min_larger_q, res_max_larger_q;
  logic [1:0]            res_sel_q;
  logic                  res_err_q;

  logic cfg_hs, beat, last_beat, cfg_legal;
  logic px_lt, px_eq, px_gt;
  logic [SIZE_BIT:0] k_ext, l_ext, le_ext;

  assign cfg_hs    = cfg_valid & cfg_ready;
  assign beat      = in_px_valid & in_px_ready;
  assign cfg_legal = (cfg_size != '0) && (cfg_size <= SIZE_BIT'(BUFF_SIZE)) && (cfg_rank < cfg_size);
  assign last_beat = beat && (cnt_d == size_q);

  assign px_lt = in_px <  pivot_q;
  assign px_eq = in_px == pivot_q;
  assign px_gt = in_px >  pivot_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cfg_hs) state_d = cfg_legal ? S_FILL : S_DONE;
      S_FILL: if (last_beat) state_d = S_DONE;
      S_DONE: begin
        if (res_ready) begin
          if (cfg_hs) state_d = cfg_legal ? S_FILL : S_DONE;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cfg_ready   = 1'b0;
    in_px_ready = 1'b0;
    filling     = 1'b0;
    res_valid   = 1'b0;
    unique case (state_q)
      S_IDLE: cfg_ready = alive_q;
      S_FILL: begin
        in_px_ready = 1'b1;
        filling     = 1'b1;
      end
      S_DONE: begin
        res_valid = 1'b1;
        cfg_ready = res_ready;
      end
      default: ;
    endcase
  end

  // Working values including the current pixel, plus rank selection on those values
  always_comb begin
    cnt_d        = cnt_q + SIZE_BIT'(1);
    lower_d      = lower_q  + SIZE_BIT'(px_lt);
    equal_d      = equal_q  + SIZE_BIT'(px_eq);
    larger_d     = larger_q + SIZE_BIT'(px_gt);
    min_lower_d  = min_lower_q;
    max_lower_d  = max_lower_q;
    min_larger_d = min_larger_q;
    max_larger_d = max_larger_q;
    if (px_lt && in_px < min_lower_q)  min_lower_d  = in_px;
    if (px_lt && in_px > max_lower_q)  max_lower_d  = in_px;
    if (px_gt && in_px < min_larger_q) min_larger_d = in_px;
    if (px_gt && in_px > max_larger_q) max_larger_d = in_px;

    k_ext  = {1'b0, rank_q};
    l_ext  = {1'b0, lower_d};
    le_ext = l_ext + {1'b0, equal_d};
    if (k_ext < l_ext) begin
      sel_d  = 2'b01;
      rank_d = rank_q;
    end else if (k_ext < le_ext) begin
      sel_d  = 2'b10;
      rank_d = SIZE_BIT'(k_ext - l_ext);
    end else begin
      sel_d  = 2'b11;
      rank_d = SIZE_BIT'(k_ext - le_ext);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pivot_q      <= '0;
      size_q       <= '0;
      rank_q       <= '0;
      cnt_q        <= '0;
      lower_q      <= '0;
      equal_q      <= '0;
      larger_q     <= '0;
      min_lower_q  <= '1;
      max_lower_q  <= '0;
      min_larger_q <= '1;
      max_larger_q <= '0;
    end else if (cfg_hs) begin
      pivot_q      <= cfg_pivot;
      size_q       <= cfg_size;
      rank_q       <= cfg_rank;
      cnt_q        <= '0;
      lower_q      <= '0;
      equal_q      <= '0;
      larger_q     <= '0;
      min_lower_q  <= '1;
      max_lower_q  <= '0;
      min_larger_q <= '1;
      max_larger_q <= '0;
    end else if (beat) begin
      cnt_q        <= cnt_d;
      lower_q      <= lower_d;
      equal_q      <= equal_d;
      larger_q     <= larger_d;
      min_lower_q  <= min_lower_d;
      max_lower_q  <= max_lower_d;
      min_larger_q <= min_larger_d;
      max_larger_q <= max_larger_d;
    end
  end

  // Result bank is loaded on the final beat (from the bypassed values) or on an illegal config
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_lower_q      <= '0;
      res_equal_q      <= '0;
      res_larger_q     <= '0;
      res_min_lower_q  <= '1;
      res_max_lower_q  <= '0;
      res_min_larger_q <= '1;
      res_max_larger_q <= '0;
      res_sel_q        <= 2'b00;
      res_rank_q       <= '0;
      res_err_q        <= 1'b0;
    end else if (cfg_hs && !cfg_legal) begin
      res_lower_q      <= '0;
      res_equal_q      <= '0;
      res_larger_q     <= '0;
      res_min_lower_q  <= '1;
      res_max_lower_q  <= '0;
      res_min_larger_q <= '1;
      res_max_larger_q <= '0;
      res_sel_q        <= 2'b00;
      res_rank_q       <= '0;
      res_err_q        <= 1'b1;
    end else if (last_beat) begin
      res_lower_q      <= lower_d;
      res_equal_q      <= equal_d;
      res_larger_q     <= larger_d;
      res_min_lower_q  <= min_lower_d;
      res_max_lower_q  <= max_lower_d;
      res_min_larger_q <= min_larger_d;
      res_max_larger_q <= max_larger_d;
      res_sel_q        <= sel_d;
      res_rank_q       <= rank_d;
      res_err_q        <= 1'b0;
    end
  end

  assign res_lower_cnt  = res_lower_q;
  assign res_equal_cnt  = res_equal_q;
  assign res_larger_cnt = res_larger_q;
  assign res_min_lower  = res_min_lower_q;
  assign res_max_lower  = res_max_lower_q;
  assign res_min_larger = res_min_larger_q;
  assign res_max_larger = res_max_larger_q;
  assign res_sel        = res_sel_q;
  assign res_rank       = res_rank_q;
  assign res_err        = res_err_q;

endmodule
